multi_channel_pushbutton: RTL and testbench

- Parametrised successor to the single-button toggle/monostable path. Serves N_CH independent pushbuttons from one clock.
- Per channel: 2-FF synchroniser, rising-edge detection, monostable lockout of LOCK_TICKS slow ticks, and a rearm only after the button is released.
- Per channel outputs: press pulse (short or long mode), toggle state, and an optional long-press event.
- Sits between raw board buttons and the stopwatch start/stop/lap/reset control logic.

---
 rtl/pushbutton_pkg.sv | 19 +
 rtl/multi_channel_pushbutton_if.sv | 34 +++
 rtl/pushbutton_channel.sv | 130 +++++++++++++
 rtl/multi_channel_pushbutton.sv | 71 +++++++
 tb/tb_multi_channel_pushbutton.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pushbutton_pkg.sv
// Shared types and defaults for the multi-channel pushbutton conditioner.
package pushbutton_pkg;

   // Per-channel conditioning state; the encoding is also exported on the
   // state_dbg field of the interface.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOCK     = 2'd1,
      WAIT_REL = 2'd2
   } pb_state_t;

   // 50 Hz slow tick from a 50 MHz master clock.
   localparam int DIV_50HZ = 1000000;

   // Default per-channel counter width and lockout length.
   localparam int DEF_CNT_W      = 8;
   localparam int DEF_LOCK_TICKS = 10;

endpackage

// File: rtl/multi_channel_pushbutton_if.sv
// Signal bundle between raw board buttons / control logic and the
// multi-channel pushbutton conditioner.
//
// There is no valid/ready handshake. btn_in, mode_long and clear_toggle are
// levels sampled on every clk_ms rising edge. press_pulse, long_press and
// tick are pulses with no back-pressure, so the consumer must sample them on
// every edge. busy and toggle_state are levels. state_dbg carries each
// channel's FSM state (pb_state_t encoding, 2 bits per channel) for
// observation only.
interface multi_channel_pushbutton_if #(
   parameter int N_CH = 4
);
   logic [N_CH-1:0]       btn_in;
   logic [N_CH-1:0]       mode_long;
   logic [N_CH-1:0]       clear_toggle;
   logic [N_CH-1:0]       press_pulse;
   logic [N_CH-1:0]       busy;
   logic [N_CH-1:0]       toggle_state;
   logic [N_CH-1:0]       long_press;
   logic                  tick;
   logic [N_CH-1:0][1:0]  state_dbg;

   // Side that owns the buttons and consumes the events.
   modport master (
      output btn_in, mode_long, clear_toggle,
      input  press_pulse, busy, toggle_state, long_press, tick, state_dbg
   );

   // The conditioner itself.
   modport slave (
      input  btn_in, mode_long, clear_toggle,
      output press_pulse, busy, toggle_state, long_press, tick, state_dbg
   );
endinterface

// File: rtl/pushbutton_channel.sv
// One pushbutton channel: 2-FF synchroniser with edge detection, a
// monostable lockout counted in slow ticks, and rearm only after release.
// Optional long-press detection is built when LONG_PRESS_EN is defined;
// otherwise long_press is tied low and no hold counter exists.
module pushbutton_channel
   import pushbutton_pkg::*;
#(
   parameter int          CNT_W      = DEF_CNT_W,
   parameter int          LOCK_TICKS = DEF_LOCK_TICKS,
   parameter int unsigned LONG_TICKS = 50
) (
   input  logic       clk_ms,
   input  logic       reset_n,
   input  logic       btn_in,
   input  logic       mode_long,
   input  logic       clear_toggle,
   input  logic       tick,
   output logic       press_pulse,
   output logic       busy,
   output logic       toggle_state,
   output logic       long_press,
   output logic [1:0] state_dbg
);

   // The tick that brings lock_cnt from LOCK_LAST to LOCK_TICKS ends the lockout.
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TICKS - 1);

   pb_state_t        state;
   logic [CNT_W-1:0] lock_cnt;
   logic             s1, s2, s3;
   logic             rise;

   // Two flops bring the button into clk_ms; the third one detects the edge.
   always_ff @(posedge clk_ms or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= btn_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise      = s2 & ~s3;
   assign state_dbg = state;

   // Accept a press, hold off for the lockout, then wait for the release.
   always_ff @(posedge clk_ms or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         press_pulse  <= 1'b0;
         busy         <= 1'b0;
         toggle_state <= 1'b0;
         lock_cnt     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (rise) begin
                  state        <= LOCK;
                  press_pulse  <= 1'b1;
                  busy         <= 1'b1;
                  toggle_state <= ~toggle_state;
                  lock_cnt     <= '0;
               end
            end
            LOCK: begin
               // Single-cycle mode drops the pulse after the entry cycle;
               // long mode keeps it high until the lockout ends.
               press_pulse <= mode_long;
               if (tick) begin
                  if (lock_cnt != '1) lock_cnt <= lock_cnt + 1'b1;
                  if (lock_cnt == LOCK_LAST) begin
                     press_pulse <= 1'b0;
                     if (s2) begin
                        state <= WAIT_REL;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end
               end
            end
            WAIT_REL: begin
               if (!s2) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               busy        <= 1'b0;
               press_pulse <= 1'b0;
            end
         endcase
         // A clear beats a press accepted on the same edge.
         if (clear_toggle) toggle_state <= 1'b0;
      end
   end

`ifdef LONG_PRESS_EN
   // hold_cnt reaches LONG_LAST one tick before the LONG_TICKS-th tick.
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);

   logic [CNT_W-1:0] hold_cnt;

   // Count held ticks from LOCK entry; fire once when the count reaches LONG_TICKS.
   always_ff @(posedge clk_ms or negedge reset_n) begin
      if (!reset_n) begin
         hold_cnt   <= '0;
         long_press <= 1'b0;
      end else begin
         long_press <= 1'b0;
         if (state == IDLE) begin
            hold_cnt <= '0;
         end else if (tick && s2 && (hold_cnt != '1)) begin
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == LONG_LAST) long_press <= 1'b1;
         end
      end
   end
`else
   // Long-press detection is not built; the output stays low.
   logic unused_long_ticks;
   assign unused_long_ticks = ^LONG_TICKS;
   assign long_press        = 1'b0;
`endif

endmodule

// File: rtl/multi_channel_pushbutton.sv
// N_CH independent pushbutton conditioners sharing one free-running slow-tick
// prescaler. Define LONG_PRESS_EN to build the per-channel long-press
// detectors; without it long_press is constant 0.
// The interface instance must be built with the same N_CH as this module.
module multi_channel_pushbutton
   import pushbutton_pkg::*;
#(
   parameter int          N_CH       = 4,
   parameter int          TICK_DIV   = DIV_50HZ,
   parameter int          CNT_W      = DEF_CNT_W,
   parameter int          LOCK_TICKS = DEF_LOCK_TICKS,
   parameter int unsigned LONG_TICKS = 50
) (
   input  logic                         clk_ms,
   input  logic                         reset_n,
   multi_channel_pushbutton_if.slave    bus
);

   localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] pre_cnt;
   logic          tick;

   // Free-running prescaler; never restarted, so lockouts start at any phase.
   always_ff @(posedge clk_ms or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt <= '0;
      end else if (pre_cnt == PRE_LAST) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   assign tick     = (pre_cnt == PRE_LAST);
   assign bus.tick = tick;

   logic [N_CH-1:0]      press_pulse;
   logic [N_CH-1:0]      busy;
   logic [N_CH-1:0]      toggle_state;
   logic [N_CH-1:0]      long_press;
   logic [N_CH-1:0][1:0] state_dbg;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      pushbutton_channel #(
         .CNT_W      (CNT_W),
         .LOCK_TICKS (LOCK_TICKS),
         .LONG_TICKS (LONG_TICKS)
      ) u_ch (
         .clk_ms       (clk_ms),
         .reset_n      (reset_n),
         .btn_in       (bus.btn_in[i]),
         .mode_long    (bus.mode_long[i]),
         .clear_toggle (bus.clear_toggle[i]),
         .tick         (tick),
         .press_pulse  (press_pulse[i]),
         .busy         (busy[i]),
         .toggle_state (toggle_state[i]),
         .long_press   (long_press[i]),
         .state_dbg    (state_dbg[i])
      );
   end

   assign bus.press_pulse  = press_pulse;
   assign bus.busy         = busy;
   assign bus.toggle_state = toggle_state;
   assign bus.long_press   = long_press;
   assign bus.state_dbg    = state_dbg;

endmodule

// File: tb/tb_multi_channel_pushbutton.sv
// Directed bench for multi_channel_pushbutton with N_CH=2, TICK_DIV=4,
// LOCK_TICKS=3, LONG_TICKS=6. Inputs change and outputs are sampled on the
// falling edge of clk_ms.
module tb_multi_channel_pushbutton;

   logic clk_ms  = 1'b0;
   logic reset_n = 1'b0;
   int   n_cmp   = 0;
   int   n_fail  = 0;

   multi_channel_pushbutton_if #(.N_CH(2)) dut_if ();

   multi_channel_pushbutton #(
      .N_CH       (2),
      .TICK_DIV   (4),
      .CNT_W      (8),
      .LOCK_TICKS (3),
      .LONG_TICKS (6)
   ) dut (
      .clk_ms  (clk_ms),
      .reset_n (reset_n),
      .bus     (dut_if.slave)
   );

   // Clock.
   always #5 clk_ms = ~clk_ms;

   task automatic step(input int n);
      repeat (n) @(negedge clk_ms);
   endtask

   // Waits up to 100 cycles for channel ch to leave busy.
   task automatic wait_idle(input int ch, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_ms);
         if (dut_if.busy[ch] === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bit ok;
      dut_if.btn_in       = 2'b00;
      dut_if.mode_long    = 2'b00;
      dut_if.clear_toggle = 2'b00;
      reset_n = 1'b0;
      step(3);
      n_cmp++;
      if ({dut_if.press_pulse, dut_if.busy, dut_if.toggle_state, dut_if.long_press, dut_if.tick} !== 9'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 0", {dut_if.press_pulse, dut_if.busy, dut_if.toggle_state, dut_if.long_press, dut_if.tick});
      end
      reset_n = 1'b1;
      step(2);
      dut_if.btn_in[0] = 1'b1;
      step(3);
      n_cmp++;
      if (dut_if.press_pulse[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL first_press: press_pulse[0]=%b want 1", dut_if.press_pulse[0]);
      end
      step(2);
      // Asynchronous reset in the middle of the lockout with the button held.
      #1 reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({dut_if.press_pulse, dut_if.busy, dut_if.toggle_state, dut_if.long_press, dut_if.tick, dut_if.state_dbg} !== 13'd0) begin
         n_fail++;
         $display("FAIL async_reset: got %b want 0", {dut_if.press_pulse, dut_if.busy, dut_if.toggle_state, dut_if.long_press, dut_if.tick, dut_if.state_dbg});
      end
      step(1);
      reset_n = 1'b1;
      step(2);
      n_cmp++;
      if (dut_if.press_pulse[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL held_early: press_pulse[0]=%b want 0", dut_if.press_pulse[0]);
      end
      step(1);
      n_cmp++;
      if ({dut_if.press_pulse[0], dut_if.busy[0], dut_if.toggle_state[0]} !== 3'b111) begin
         n_fail++;
         $display("FAIL held_press: pulse/busy/toggle=%b want 111", {dut_if.press_pulse[0], dut_if.busy[0], dut_if.toggle_state[0]});
      end
      dut_if.btn_in[0] = 1'b0;
      wait_idle(0, ok);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL reset_idle: busy[0]=1 after 100 cycles want 0");
      end
   endtask

   task automatic test_tick();
      int ticks = 0;
      bit prev = 1'b0;
      bit dbl  = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         if (dut_if.tick === 1'b1) begin
            ticks++;
            if (prev) dbl = 1'b1;
         end
         prev = (dut_if.tick === 1'b1);
      end
      n_cmp++;
      if (ticks !== 3 || dbl) begin
         n_fail++;
         $display("FAIL tick_rate: %0d ticks in 12 cycles (back-to-back=%0d) want 3 (0)", ticks, dbl);
      end
   endtask

   task automatic test_clean_press();
      int pulses = 0;
      int busys  = 0;
      bit ok;
      dut_if.clear_toggle[0] = 1'b1;
      step(1);
      dut_if.clear_toggle[0] = 1'b0;
      n_cmp++;
      if (dut_if.toggle_state[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_toggle: toggle_state[0]=%b want 0", dut_if.toggle_state[0]);
      end
      dut_if.btn_in[0] = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         step(1);
         if (dut_if.press_pulse[0] === 1'b1) pulses++;
         if (dut_if.busy[0] === 1'b1) busys++;
      end
      n_cmp++;
      if (pulses !== 1) begin
         n_fail++;
         $display("FAIL clean_pulse: %0d pulse cycles want 1", pulses);
      end
      n_cmp++;
      if (busys !== 38) begin
         n_fail++;
         $display("FAIL clean_busy: %0d busy cycles want 38", busys);
      end
      n_cmp++;
      if ({dut_if.toggle_state[0], dut_if.state_dbg[0]} !== 3'b110) begin
         n_fail++;
         $display("FAIL clean_state: toggle/state=%b want 110", {dut_if.toggle_state[0], dut_if.state_dbg[0]});
      end
      dut_if.btn_in[0] = 1'b0;
      step(2);
      n_cmp++;
      if (dut_if.busy[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL release_early: busy[0]=%b want 1", dut_if.busy[0]);
      end
      step(1);
      n_cmp++;
      if (dut_if.busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL release_idle: busy[0]=%b want 0", dut_if.busy[0]);
      end
      wait_idle(0, ok);
   endtask

   task automatic test_bounce();
      int pulses = 0;
      bit ok;
      for (int i = 0; i < 40; i++) begin
         dut_if.btn_in[0] = (i < 10) ? ~((i >> 1) & 1) : 1'b1;
         step(1);
         if (dut_if.press_pulse[0] === 1'b1) pulses++;
      end
      n_cmp++;
      if (pulses !== 1) begin
         n_fail++;
         $display("FAIL bounce_pulse: %0d pulse cycles want 1", pulses);
      end
      n_cmp++;
      if (dut_if.toggle_state[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL bounce_toggle: toggle_state[0]=%b want 0", dut_if.toggle_state[0]);
      end
      dut_if.btn_in[0] = 1'b0;
      wait_idle(0, ok);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL bounce_idle: busy[0]=1 after 100 cycles want 0");
      end
   endtask

   task automatic test_long_mode_release();
      int pulses = 0;
      bit saw_wait = 1'b0;
      bit ok;
      dut_if.mode_long[1] = 1'b1;
      for (int i = 0; i < 30; i++) begin
         dut_if.btn_in[1] = (i < 5);
         step(1);
         if (dut_if.press_pulse[1] === 1'b1) pulses++;
         if (dut_if.state_dbg[1] === 2'd2) saw_wait = 1'b1;
      end
      n_cmp++;
      if (pulses < 9 || pulses > 12) begin
         n_fail++;
         $display("FAIL long_mode_len: %0d pulse cycles want 9..12", pulses);
      end
      n_cmp++;
      if (saw_wait || dut_if.busy[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL long_mode_exit: saw WAIT_REL=%0d busy[1]=%b want 0 and 0", saw_wait, dut_if.busy[1]);
      end
      dut_if.btn_in[1] = 1'b1;
      step(3);
      n_cmp++;
      if (dut_if.press_pulse[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL long_mode_repress: press_pulse[1]=%b want 1", dut_if.press_pulse[1]);
      end
      dut_if.btn_in[1] = 1'b0;
      wait_idle(1, ok);
      dut_if.mode_long[1] = 1'b0;
      n_cmp++;
      if (!ok || dut_if.toggle_state[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL long_mode_idle: idle=%0d toggle_state[1]=%b want 1 and 0", ok, dut_if.toggle_state[1]);
      end
   endtask

   task automatic test_clear_and_simultaneous();
      bit ok;
      dut_if.btn_in[0] = 1'b1;
      step(2);
      dut_if.clear_toggle[0] = 1'b1;
      step(1);
      dut_if.clear_toggle[0] = 1'b0;
      n_cmp++;
      if ({dut_if.press_pulse[0], dut_if.toggle_state[0]} !== 2'b10) begin
         n_fail++;
         $display("FAIL clear_wins: pulse/toggle=%b want 10", {dut_if.press_pulse[0], dut_if.toggle_state[0]});
      end
      dut_if.btn_in[0] = 1'b0;
      wait_idle(0, ok);
      dut_if.btn_in = 2'b11;
      step(2);
      n_cmp++;
      if (dut_if.press_pulse !== 2'b00) begin
         n_fail++;
         $display("FAIL simul_early: press_pulse=%b want 00", dut_if.press_pulse);
      end
      step(1);
      n_cmp++;
      if ({dut_if.press_pulse, dut_if.toggle_state} !== 4'b1111) begin
         n_fail++;
         $display("FAIL simul_press: pulse/toggle=%b want 1111", {dut_if.press_pulse, dut_if.toggle_state});
      end
      dut_if.btn_in = 2'b00;
      wait_idle(0, ok);
      wait_idle(1, ok);
      n_cmp++;
      if (!ok || dut_if.busy !== 2'b00) begin
         n_fail++;
         $display("FAIL simul_idle: busy=%b want 00", dut_if.busy);
      end
   endtask

   task automatic test_long_press();
      int lp_cnt  = 0;
      int tick_n  = 0;
      int lp_tick = -1;
      bit ok;
      dut_if.btn_in[0] = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         step(1);
         if (dut_if.long_press[0] === 1'b1) begin
            lp_cnt++;
            lp_tick = tick_n;
         end
         if (i >= 3 && dut_if.tick === 1'b1) tick_n++;
      end
`ifdef LONG_PRESS_EN
      n_cmp++;
      if (lp_cnt !== 1 || lp_tick !== 6) begin
         n_fail++;
         $display("FAIL long_press: %0d pulses after tick %0d want 1 after tick 6", lp_cnt, lp_tick);
      end
`else
      n_cmp++;
      if (lp_cnt !== 0) begin
         n_fail++;
         $display("FAIL long_press_off: %0d pulses want 0", lp_cnt);
      end
`endif
      dut_if.btn_in[0] = 1'b0;
      wait_idle(0, ok);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL long_idle: busy[0]=1 after 100 cycles want 0");
      end
   endtask

   initial begin
      test_reset();
      test_tick();
      test_clean_press();
      test_bounce();
      test_long_mode_release();
      test_clear_and_simultaneous();
      test_long_press();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
